// File: rtl/uart_pkg.sv
// Shared types and counter widths for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StLaunch,
    StWaitDone,
    StGap
  } sched_state_e;

  // GAP_TICKS is at most 15; LAUNCH_TIMEOUT must fit in 16 bits.
  localparam int unsigned GapCntW     = 4;
  localparam int unsigned TimeoutCntW = 16;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant and wraps.
module uart_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IdxW-1:0]    idx,
  output logic               any
);

  logic [IdxW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IdxW'((32'(last) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte sources with round-robin arbitration.
// Optional build macro UART_TX_SCHED_URGENT_EN gives requester 0 absolute priority.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_TICKS      = 1,
  parameter int unsigned LAUNCH_TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       baud_tick,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       sched_busy,
  output logic                       timeout_err,
  input  logic                       err_clr
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam logic [GapCntW-1:0] GapLast =
      GapCntW'(GAP_TICKS == 0 ? 0 : GAP_TICKS - 1);
  localparam logic [TimeoutCntW-1:0] TimeoutLast = TimeoutCntW'(LAUNCH_TIMEOUT - 1);

  sched_state_e           state_q;
  logic                   tx_start_q;
  logic [7:0]             tx_data_q;
  logic [IdxW-1:0]        grant_id_q;
  logic [IdxW-1:0]        last_grant_q;
  logic [GapCntW-1:0]     gap_cnt_q;
  logic [TimeoutCntW-1:0] to_cnt_q;
  logic                   timeout_err_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IdxW-1:0]    arb_idx;
  logic               arb_any;
  logic [NUM_REQ-1:0] win_gnt;
  logic [IdxW-1:0]    win_idx;
  logic [IdxW-1:0]    last_upd;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req  (req_valid),
    .last (last_grant_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

`ifdef UART_TX_SCHED_URGENT_EN
  // Urgent grants to requester 0 leave the rotation pointer untouched.
  assign win_gnt  = req_valid[0] ? NUM_REQ'(1) : arb_gnt;
  assign win_idx  = req_valid[0] ? '0 : arb_idx;
  assign last_upd = req_valid[0] ? last_grant_q : arb_idx;
`else
  assign win_gnt  = arb_gnt;
  assign win_idx  = arb_idx;
  assign last_upd = arb_idx;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      last_grant_q  <= IdxW'(NUM_REQ - 1);
      gap_cnt_q     <= '0;
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      // A timeout below overrides this clear when both land in one cycle.
      if (err_clr) timeout_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req_valid) state_q <= StGrant;
        end
        StGrant: begin
          if (arb_any) begin
            tx_data_q    <= req_data[{win_idx, 3'b000} +: 8];
            grant_id_q   <= win_idx;
            last_grant_q <= last_upd;
            tx_start_q   <= 1'b1;
            to_cnt_q     <= '0;
            state_q      <= StLaunch;
          end else begin
            state_q <= StIdle;
          end
        end
        StLaunch: begin
          if (tx_busy) begin
            tx_start_q <= 1'b0;
            state_q    <= StWaitDone;
          end else if (to_cnt_q == TimeoutLast) begin
            tx_start_q    <= 1'b0;
            timeout_err_q <= 1'b1;
            to_cnt_q      <= '0;
            state_q       <= StIdle;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        StWaitDone: begin
          if (!tx_busy) begin
            if (GAP_TICKS > 0) begin
              gap_cnt_q <= '0;
              state_q   <= StGap;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StGap: begin
          if (baud_tick) begin
            if (gap_cnt_q == GapLast) begin
              gap_cnt_q <= '0;
              state_q   <= StIdle;
            end else begin
              gap_cnt_q <= gap_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready   = (state_q == StGrant) ? win_gnt : '0;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign sched_busy  = (state_q != StIdle);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed-random bench for uart_tx_scheduler with a queue-level arbitration model.
module tb_uart_tx_scheduler;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           baud_tick;
  logic           tx_busy;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic [1:0]     grant_id;
  logic           sched_busy;
  logic           timeout_err;
  logic           err_clr;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] rv;
  logic [7:0]   bytes [N];
  int           last_m;

  uart_tx_scheduler #(
    .NUM_REQ        (N),
    .GAP_TICKS      (1),
    .LAUNCH_TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .baud_tick   (baud_tick),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .grant_id    (grant_id),
    .sched_busy  (sched_busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next owner: first valid requester after the last one served, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef UART_TX_SCHED_URGENT_EN
    if (v[0]) return 0;
`endif
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (last + i) % N;
      if (((v >> c) & 4'd1) != 4'd0) return c;
    end
    return -1;
  endfunction

  function automatic int next_last(input logic [N-1:0] v, input int w, input int last);
`ifdef UART_TX_SCHED_URGENT_EN
    if (v[0]) return last;
`endif
    return w;
  endfunction

  task automatic drive();
    req_valid = rv;
    for (int k = 0; k < N; k++) req_data[8*k +: 8] = bytes[k];
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tx_start"}, 32'(tx_start), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_grant_id"}, 32'(grant_id), 0);
    check({tag, "_sched_busy"}, 32'(sched_busy), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  // Entry: at a negedge, DUT idle, rv nonzero and driven. Exit: at a negedge, DUT idle.
  // mode 0 drops the served lane, 1 refills it, 2 chooses randomly.
  task automatic frame(input int lat, input int blen, input int mode);
    int w;
    int gw;
    logic [7:0] exp_b;
    w     = pick(rv, last_m);
    exp_b = bytes[w];
    @(negedge clk);
    check("grant_ready", 32'(req_ready), 32'(1) << w);
    check("grant_busy", 32'(sched_busy), 1);
    last_m = next_last(rv, w, last_m);
    @(negedge clk);
    check("launch_start", 32'(tx_start), 1);
    check("launch_data", 32'(tx_data), 32'(exp_b));
    check("launch_id", 32'(grant_id), 32'(w));
    check("launch_ready", 32'(req_ready), 0);
    if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) bytes[w] = 8'($urandom);
    else rv[w] = 1'b0;
    drive();
    repeat (lat) begin
      @(negedge clk);
      check("launch_hold", 32'(tx_start), 1);
    end
    tx_busy = 1'b1;
    @(negedge clk);
    check("wait_start_low", 32'(tx_start), 0);
    check("wait_busy", 32'(sched_busy), 1);
    repeat (blen) begin
      baud_tick = 1'($urandom);
      @(negedge clk);
      check("wait_data", 32'(tx_data), 32'(exp_b));
    end
    baud_tick = 1'b0;
    tx_busy   = 1'b0;
    @(negedge clk);
    check("gap_busy", 32'(sched_busy), 1);
    gw = $urandom_range(0, 2);
    repeat (gw) begin
      @(negedge clk);
      check("gap_hold", 32'(sched_busy), 1);
    end
    baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
    check("idle_after_gap", 32'(sched_busy), 0);
    check("idle_data", 32'(tx_data), 32'(exp_b));
  endtask

  task automatic to_frame(input bit hold_clr);
    int w;
    int n;
    w = pick(rv, last_m);
    @(negedge clk);
    check("to_grant_ready", 32'(req_ready), 32'(1) << w);
    last_m = next_last(rv, w, last_m);
    if (hold_clr) err_clr = 1'b1;
    @(negedge clk);
    check("to_grant_id", 32'(grant_id), 32'(w));
    if (hold_clr) check("to_clr_in_launch", 32'(timeout_err), 0);
    rv[w] = 1'b0;
    drive();
    n = 0;
    while (tx_start === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("to_launch_len", 32'(n), 15);
    check("to_start_low", 32'(tx_start), 0);
    check("to_idle", 32'(sched_busy), 0);
    check("to_err_set", 32'(timeout_err), 1);
    err_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tx_busy = 1'b0; baud_tick = 1'b0; err_clr = 1'b0;
    rv = '0;
    for (int k = 0; k < N; k++) bytes[k] = 8'h00;
    drive();
    last_m = N - 1;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;

    // Single requester 2 with 0xA5.
    rv = 4'b0100; bytes[2] = 8'hA5; drive();
    frame(2, 2, 0);

    // Fresh reset, then all four valid: rotation from requester 0.
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("rst2");
    rst_n = 1'b1; last_m = N - 1;
    rv = '1;
    for (int k = 0; k < N; k++) bytes[k] = 8'($urandom);
    drive();
    for (int f = 0; f < 4; f++) frame($urandom_range(0, 4), $urandom_range(0, 3), 1);

    // Random arrivals; requesters only add valids, never withdraw unserved ones.
    for (int r = 0; r < 24; r++) begin
      logic [N-1:0] add;
      add = 4'($urandom);
      for (int k = 0; k < N; k++)
        if (add[k] && !rv[k]) begin rv[k] = 1'b1; bytes[k] = 8'($urandom); end
      if (rv == '0) begin rv[r % N] = 1'b1; bytes[r % N] = 8'($urandom); end
      drive();
      frame($urandom_range(0, 4), $urandom_range(0, 3), 2);
    end
    for (int k = 0; k < N; k++) begin
      if (rv[k]) begin
        rv = 4'(1) << k;
        drive();
        frame(1, 1, 0);
      end
    end
    rv = '0; drive();

    // Launch timeout, then timeout coinciding with err_clr.
    rv[1] = 1'b1; bytes[1] = 8'($urandom); drive();
    to_frame(1'b0);
    rv[3] = 1'b1; bytes[3] = 8'($urandom); drive();
    to_frame(1'b1);
    @(negedge clk);
    check("err_sticky", 32'(timeout_err), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", 32'(timeout_err), 0);

    // Reset during WAIT_DONE with everyone pending.
    rv = '1;
    for (int k = 0; k < N; k++) bytes[k] = 8'($urandom);
    drive();
    @(negedge clk);
    @(negedge clk);
    tx_busy = 1'b1;
    @(negedge clk);
    check("mid_wait_start_low", 32'(tx_start), 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("mid_rst");
    @(negedge clk);
    check("mid_rst_no_start", 32'(tx_start), 0);
    rst_n = 1'b1; tx_busy = 1'b0; last_m = N - 1;
    for (int k = 0; k < N; k++) bytes[k] = 8'($urandom);
    drive();
    frame(1, 1, 0);
    check("post_rst_first_grant", 32'(last_m), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one transmitter (2..8).
REQ-002 Parameter GAP_TICKS, 1, idle baud ticks inserted between consecutive frames (0..15).
REQ-003 Parameter LAUNCH_TIMEOUT, 1023, max clocks from tx_start to tx_busy high before abort.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester byte available.
REQ-007 req_data  input  8*NUM_REQ  packed bytes; requester k in bits [8k+7:8k].
REQ-008 req_ready  output  NUM_REQ  one-hot accept pulse; byte taken when valid&ready.
REQ-009 baud_tick  input  1  baud enable shared with the transmitter.
REQ-010 tx_busy  input  1  transmitter busy status.
REQ-011 tx_start  output  1  launch request to transmitter.
REQ-012 tx_data  output  8  byte to transmitter; stable from tx_start rise until return to IDLE.
REQ-013 grant_id  output  $clog2(NUM_REQ)  requester owning current frame.
REQ-014 sched_busy  output  1  high in every state except IDLE.
REQ-015 timeout_err  output  1  sticky launch-timeout flag.
REQ-016 err_clr  input  1  clears timeout_err.

Function
REQ-017 States SHALL be IDLE, GRANT, LAUNCH, WAIT_DONE, GAP.
REQ-018 IDLE: any req_valid -> GRANT next cycle; else stay.
REQ-019 GRANT (1 cycle): round-robin winner chosen starting at last_grant+1 mod NUM_REQ; req_ready[winner]=1, req_data captured into tx_data, grant_id and last_grant updated; -> LAUNCH.
REQ-020 GRANT with winner's valid dropped SHALL NOT occur: winner chosen from req_valid sampled in that same cycle; requesters hold valid until accepted.
REQ-021 LAUNCH: tx_start=1 held until tx_busy=1 is seen, then -> WAIT_DONE with tx_start=0 same edge.
REQ-022 LAUNCH clock counter reaching LAUNCH_TIMEOUT with tx_busy=0: set timeout_err, drop tx_start, -> IDLE; byte is discarded.
REQ-023 WAIT_DONE: on tx_busy=0 -> GAP if GAP_TICKS>0, else IDLE.
REQ-024 GAP: counts baud_tick pulses; after GAP_TICKS ticks -> IDLE.
REQ-025 Back-to-back: with requests pending, minimum clocks between frames = 2 (GAP->IDLE->GRANT) plus gap.
REQ-026 Round-robin SHALL be starvation-free: with all valid, grants cycle 0,1,..,NUM_REQ-1,0.
REQ-027 err_clr and timeout event in the same cycle: set wins.
REQ-028 req_ready asserted only in GRANT, at most one bit high.

Reset
REQ-029 rst_n=0 at a clock edge: state=IDLE, tx_start=0, tx_data=0, req_ready=0, grant_id=0, last_grant=NUM_REQ-1, counters=0, sched_busy=0, timeout_err=0.
REQ-030 Reset mid-frame SHALL abandon the frame without further tx_start; first grant afterwards goes to requester 0 if valid.

Configuration
REQ-031 Macro UART_TX_SCHED_URGENT_EN defined: requester 0 SHALL win every GRANT in which req_valid[0]=1, others round-robin among themselves; last_grant not updated by urgent grants.
REQ-032 Macro undefined: pure round-robin per REQ-019/026, no priority logic present.

Structure
REQ-033 Shared package uart_pkg SHALL hold the sched state enum and GAP/timeout counter width constants.
REQ-034 One sub-module uart_rr_arbiter (request vector, last pointer -> one-hot grant, index) is natural; FSM stays in uart_tx_scheduler.

Verification
REQ-035 Single request: req_valid=4'b0100, data 8'hA5 -> req_ready=4'b0100 one cycle, grant_id=2, tx_data=8'hA5, tx_start until tx_busy rises.
REQ-036 All four valid, 4 frames -> grant order 0,1,2,3, each byte sent once, GAP_TICKS=1 tick between frames.
REQ-037 tx_busy tied 0, LAUNCH_TIMEOUT=15 -> tx_start drops after 15 clocks, timeout_err=1, state IDLE; err_clr=1 -> timeout_err=0.
REQ-038 rst_n=0 during WAIT_DONE with pending requests -> all outputs reset values next edge; after release requester 0 granted first.
REQ-039 UART_TX_SCHED_URGENT_EN, req_valid[0] reasserted every frame plus 1,2 valid -> 0 granted every frame; without macro 0,1,2 rotate.
REQ-040 err_clr and timeout in same cycle -> timeout_err=1.
